// File: rtl/mem_stage_lsx_if.sv
// MEM stage connection bundle: EXE->MEM entry, MEM->WB entry, data SRAM response and ID forwarding.
// The DUT side uses the slave modport; the driving environment uses the master modport.
interface mem_stage_lsx_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int RA_W = 5
);
  localparam int ES_BUS_W = 8 + RA_W + XLEN + PC_W;
  localparam int WS_BUS_W = 1 + RA_W + XLEN + PC_W;
  localparam int FWD_W    = RA_W + XLEN + 2;

  logic                ws_allowin;
  logic                ms_allowin;
  logic                es_to_ms_valid;
  logic [ES_BUS_W-1:0] es_to_ms_bus;
  logic                ms_to_ws_valid;
  logic [WS_BUS_W-1:0] ms_to_ws_bus;
  logic                ms_flush;
  logic                data_sram_data_ok;
  logic [XLEN-1:0]     data_sram_rdata;
  logic [FWD_W-1:0]    ms_fwd_bus;

  modport master (
    output ws_allowin,
    output es_to_ms_valid,
    output es_to_ms_bus,
    output ms_flush,
    output data_sram_data_ok,
    output data_sram_rdata,
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_fwd_bus
  );

  modport slave (
    input  ws_allowin,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  ms_flush,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_fwd_bus
  );
endinterface

// File: rtl/mem_stage_lsx.sv
// Memory-access pipeline stage: waits on variable-latency SRAM data, buffers it across WB stalls,
// extracts/extends load lanes, drops responses of flushed loads and drives the ID forwarding bus.
//   state   | meaning
//   ST_IDLE | no entry, or entry needs no SRAM response (ready immediately)
//   ST_WAIT | entry issued an SRAM request and its data_ok has not arrived
//   ST_HOLD | response captured in r_rdata_buf while WB stalls
module mem_stage_lsx #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int RA_W      = 5,
  parameter int MAX_OUTST = 2
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  mem_stage_lsx_if.slave  bus
);
  localparam int ES_BUS_W = 8 + RA_W + XLEN + PC_W;
  localparam int OFF_W    = $clog2(XLEN / 8);
  localparam int DROP_W   = $clog2(MAX_OUTST + 1);
  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(MAX_OUTST);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ms_valid;
  logic [ES_BUS_W-1:0] r_es_bus;
  logic [XLEN-1:0]     r_rdata_buf;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic                w_mem_req;
  logic [4:0]          w_ld_op;
  logic                w_res_from_mem;
  logic                w_gr_we;
  logic [RA_W-1:0]     w_dest;
  logic [XLEN-1:0]     w_alu_result;
  logic [PC_W-1:0]     w_pc;
  logic                w_in_mem_req;

  logic                w_data_ok_entry;
  logic                w_ready_go;
  logic                w_allowin;
  logic                w_drop_inc;
  logic                w_drop_dec;

  logic [XLEN-1:0]     w_rdata;
  logic [OFF_W-1:0]    w_off;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_word;
  logic [XLEN-1:0]     w_load;
  logic [XLEN-1:0]     w_final;
  logic                w_fwd_we;
  logic                w_fwd_blk;

  assign {w_mem_req, w_ld_op, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_es_bus;
  assign w_in_mem_req = bus.es_to_ms_bus[ES_BUS_W-1];

  // A data_ok seen while drops are pending belongs to an older, flushed load.
  assign w_data_ok_entry = bus.data_sram_data_ok && (r_drop_cnt == '0);
  assign w_ready_go      = (r_state != ST_WAIT) || w_data_ok_entry;
  assign w_allowin       = !r_ms_valid || (w_ready_go && bus.ws_allowin);
  assign w_drop_inc      = r_ms_valid && bus.ms_flush && (r_state == ST_WAIT) && !w_data_ok_entry;
  assign w_drop_dec      = bus.data_sram_data_ok && (r_drop_cnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    if (bus.ms_flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_allowin) begin
      w_state_nxt = (bus.es_to_ms_valid && w_in_mem_req) ? ST_WAIT : ST_IDLE;
    end else if ((r_state == ST_WAIT) && w_data_ok_entry) begin
      w_state_nxt = ST_HOLD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= ST_IDLE;
      r_ms_valid  <= 1'b0;
      r_es_bus    <= '0;
      r_rdata_buf <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.ms_flush) begin
        r_ms_valid <= 1'b0;
      end else if (w_allowin) begin
        r_ms_valid <= bus.es_to_ms_valid;
      end
      if (w_allowin && bus.es_to_ms_valid) begin
        r_es_bus <= bus.es_to_ms_bus;
      end
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_HOLD)) begin
        r_rdata_buf <= bus.data_sram_rdata;
      end
      if (w_drop_inc && !w_drop_dec && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + DROP_ONE;
      end else if (w_drop_dec && !w_drop_inc) begin
        r_drop_cnt <= r_drop_cnt - DROP_ONE;
      end
    end
  end

  assign w_rdata = (r_state == ST_HOLD) ? r_rdata_buf : bus.data_sram_rdata;
  assign w_off   = w_alu_result[OFF_W-1:0];
  assign w_byte  = w_rdata[8*w_off +: 8];
  assign w_half  = w_rdata[16*w_off[OFF_W-1:1] +: 16];

  generate
    if (XLEN == 64) begin : g_word64
      assign w_word = w_rdata[32*w_off[OFF_W-1] +: 32];
    end else begin : g_word32
      assign w_word = w_rdata[31:0];
    end
  endgenerate

  // ld_op = {b, bu, h, hu, w}; zero ld_op returns the raw XLEN word.
  always_comb begin
    w_load = w_rdata;
    if (w_ld_op[4]) begin
      w_load = XLEN'($signed(w_byte));
    end else if (w_ld_op[3]) begin
      w_load = XLEN'(w_byte);
    end else if (w_ld_op[2]) begin
      w_load = XLEN'($signed(w_half));
    end else if (w_ld_op[1]) begin
      w_load = XLEN'(w_half);
    end else if (w_ld_op[0]) begin
      w_load = XLEN'($signed(w_word));
    end
  end

  assign w_final   = w_res_from_mem ? w_load : w_alu_result;
  assign w_fwd_we  = r_ms_valid && w_gr_we && (w_dest != '0);
  assign w_fwd_blk = w_fwd_we && w_res_from_mem && !w_ready_go;

  assign bus.ms_allowin     = w_allowin;
  assign bus.ms_to_ws_valid = r_ms_valid && w_ready_go && !bus.ms_flush;
  assign bus.ms_to_ws_bus   = {w_gr_we, w_dest, w_final, w_pc};
  assign bus.ms_fwd_bus     = {w_fwd_we, w_fwd_blk, w_dest, w_final};
endmodule

// File: tb/tb_mem_stage_lsx.sv
// Scoreboard bench for mem_stage_lsx: stimulus pushes expected WB payloads, a monitor pops them
// whenever the stage hands an entry to WB; cycle-level checks cover stalls, flush drops and reset.
module tb_mem_stage_lsx;
  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int RA_W = 5;
  localparam int MAX_OUTST = 2;
  localparam int ES_BUS_W = 8 + RA_W + XLEN + PC_W;
  localparam int WS_BUS_W = 1 + RA_W + XLEN + PC_W;
  localparam int FWD_WE  = RA_W + XLEN + 1;
  localparam int FWD_BLK = RA_W + XLEN;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;
  localparam logic [4:0] LD_0  = 5'b00000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_lsx_if #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)) bif ();

  mem_stage_lsx #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bif)
  );

  int errors = 0;
  int checks = 0;
  logic [WS_BUS_W-1:0] exp_q[$];

  function automatic logic [ES_BUS_W-1:0] es(input logic mreq, input logic [4:0] ld, input logic rfm,
                                              input logic we, input logic [4:0] dest,
                                              input logic [31:0] alu, input logic [31:0] pc);
    return {mreq, ld, rfm, we, dest, alu, pc};
  endfunction

  function automatic logic [WS_BUS_W-1:0] ws(input logic we, input logic [4:0] dest,
                                              input logic [31:0] res, input logic [31:0] pc);
    return {we, dest, res, pc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bif.ms_to_ws_valid && bif.ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got %0h expected no transfer", bif.ms_to_ws_bus);
      end else begin
        chk("wb_bus", bif.ms_to_ws_bus, exp_q.pop_front());
      end
    end
    if (int'(dut.r_drop_cnt) > MAX_OUTST) begin
      errors++;
      $display("FAIL drop_cnt_range: got %0d expected <= %0d", dut.r_drop_cnt, MAX_OUTST);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_ok(input logic ok, input logic [31:0] d);
    bif.data_sram_data_ok = ok;
    bif.data_sram_rdata   = d;
  endtask

  task automatic send(input logic [ES_BUS_W-1:0] b);
    int n;
    n = 0;
    bif.es_to_ms_bus   = b;
    bif.es_to_ms_valid = 1'b1;
    @(negedge clk);
    while (!bif.ms_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bif.ms_allowin) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got allowin=0 expected allowin=1 within 20 cycles");
    end
    step();
    bif.es_to_ms_valid = 1'b0;
  endtask

  task automatic ld_now(input string nm, input logic [4:0] op, input logic [31:0] alu,
                        input logic [31:0] rd, input logic [31:0] res, input logic [4:0] dest,
                        input logic [31:0] pc);
    exp_q.push_back(ws(1'b1, dest, res, pc));
    send(es(1'b1, op, 1'b1, 1'b1, dest, alu, pc));
    drv_ok(1'b1, rd);
    @(negedge clk);
    chk(nm, bif.ms_to_ws_valid, 1'b1);
    step();
    drv_ok(1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    bif.ws_allowin = 1'b1;
    bif.es_to_ms_valid = 1'b0;
    bif.es_to_ms_bus = '0;
    bif.ms_flush = 1'b0;
    drv_ok(1'b0, 32'h0);
    repeat (2) step();
    @(negedge clk);
    chk("rst_allowin", bif.ms_allowin, 1'b1);
    chk("rst_to_ws_valid", bif.ms_to_ws_valid, 1'b0);
    chk("rst_fwd_we_blk", {bif.ms_fwd_bus[FWD_WE], bif.ms_fwd_bus[FWD_BLK]}, 2'b00);
    step();
    resetn = 1'b1;

    // Same-cycle data_ok lane/extend vectors.
    ld_now("ldb_lat",  LD_B,  32'h1003, 32'h80AB_CDEF, 32'hFFFF_FF80, 5'd3, 32'h100);
    ld_now("ldbu_lat", LD_BU, 32'h1003, 32'h80AB_CDEF, 32'h0000_0080, 5'd3, 32'h104);
    ld_now("ldb0_lat", LD_B,  32'h1000, 32'h80AB_CDEF, 32'hFFFF_FFEF, 5'd3, 32'h108);
    ld_now("ldhu_lat", LD_HU, 32'h1002, 32'h8001_1234, 32'h0000_8001, 5'd3, 32'h10C);
    ld_now("ldh0_lat", LD_H,  32'h1001, 32'h8001_9234, 32'hFFFF_9234, 5'd3, 32'h110);
    ld_now("raw_lat",  LD_0,  32'h1002, 32'h80AB_CDEF, 32'h80AB_CDEF, 5'd3, 32'h114);

    // ld.h with data_ok three cycles late.
    exp_q.push_back(ws(1'b1, 5'd4, 32'hFFFF_8001, 32'h200));
    send(es(1'b1, LD_H, 1'b1, 1'b1, 5'd4, 32'h2002, 32'h200));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldh_wait_blk", bif.ms_fwd_bus[FWD_BLK], 1'b1);
      chk("ldh_wait_allowin", bif.ms_allowin, 1'b0);
      chk("ldh_wait_valid", bif.ms_to_ws_valid, 1'b0);
      step();
    end
    drv_ok(1'b1, 32'h8001_1234);
    @(negedge clk);
    chk("ldh_done_valid", bif.ms_to_ws_valid, 1'b1);
    chk("ldh_done_blk", bif.ms_fwd_bus[FWD_BLK], 1'b0);
    step();
    drv_ok(1'b0, 32'h0);

    // ld.w response arrives while WB stalls for two cycles.
    exp_q.push_back(ws(1'b1, 5'd6, 32'h1234_5678, 32'h300));
    send(es(1'b1, LD_W, 1'b1, 1'b1, 5'd6, 32'h3000, 32'h300));
    bif.ws_allowin = 1'b0;
    drv_ok(1'b1, 32'h1234_5678);
    @(negedge clk);
    chk("ldw_stall_valid", bif.ms_to_ws_valid, 1'b1);
    step();
    drv_ok(1'b0, 32'h0000_DEAD);
    @(negedge clk);
    chk("ldw_hold_blk", bif.ms_fwd_bus[FWD_BLK], 1'b0);
    chk("ldw_hold_allowin", bif.ms_allowin, 1'b0);
    step();
    bif.ws_allowin = 1'b1;
    @(negedge clk);
    chk("ldw_release_valid", bif.ms_to_ws_valid, 1'b1);
    step();
    drv_ok(1'b0, 32'h0);

    // Flush a waiting load; its late response must be dropped.
    send(es(1'b1, LD_W, 1'b1, 1'b1, 5'd7, 32'h4000, 32'h400));
    bif.ms_flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", bif.ms_to_ws_valid, 1'b0);
    step();
    bif.ms_flush = 1'b0;
    exp_q.push_back(ws(1'b1, 5'd7, 32'h0000_5555, 32'h404));
    send(es(1'b1, LD_W, 1'b1, 1'b1, 5'd7, 32'h4004, 32'h404));
    drv_ok(1'b1, 32'h0000_AAAA);
    @(negedge clk);
    chk("drop_valid", bif.ms_to_ws_valid, 1'b0);
    chk("drop_blk", bif.ms_fwd_bus[FWD_BLK], 1'b1);
    step();
    drv_ok(1'b1, 32'h0000_5555);
    @(negedge clk);
    chk("after_drop_valid", bif.ms_to_ws_valid, 1'b1);
    step();
    drv_ok(1'b0, 32'h0);

    // Reset with a drop pending and then with data held in the buffer.
    send(es(1'b1, LD_W, 1'b1, 1'b1, 5'd8, 32'h5000, 32'h500));
    bif.ms_flush = 1'b1;
    step();
    bif.ms_flush = 1'b0;
    send(es(1'b1, LD_W, 1'b1, 1'b1, 5'd8, 32'h5004, 32'h504));
    drv_ok(1'b1, 32'h0000_00AA);
    step();
    bif.ws_allowin = 1'b0;
    drv_ok(1'b1, 32'h0000_00BB);
    step();
    drv_ok(1'b0, 32'h0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    bif.ws_allowin = 1'b1;
    @(negedge clk);
    chk("rst2_allowin", bif.ms_allowin, 1'b1);
    chk("rst2_to_ws_valid", bif.ms_to_ws_valid, 1'b0);
    chk("rst2_fwd_we", bif.ms_fwd_bus[FWD_WE], 1'b0);
    step();
    ld_now("rst2_ld_lat", LD_W, 32'h6000, 32'h0000_0077, 32'h0000_0077, 5'd9, 32'h600);

    // Store: waits for data_ok but writes nothing back.
    exp_q.push_back(ws(1'b0, 5'd0, 32'h0000_0500, 32'h700));
    send(es(1'b1, LD_0, 1'b0, 1'b0, 5'd0, 32'h0000_0500, 32'h700));
    @(negedge clk);
    chk("st_wait_allowin", bif.ms_allowin, 1'b0);
    step();
    drv_ok(1'b1, 32'h0);
    @(negedge clk);
    chk("st_done_valid", bif.ms_to_ws_valid, 1'b1);
    step();
    drv_ok(1'b0, 32'h0);

    // Non-memory ops pass in one cycle and forward.
    exp_q.push_back(ws(1'b1, 5'd5, 32'h42, 32'h800));
    send(es(1'b0, LD_0, 1'b0, 1'b1, 5'd5, 32'h42, 32'h800));
    @(negedge clk);
    chk("add_fwd_bus", bif.ms_fwd_bus, {1'b1, 1'b0, 5'd5, 32'h42});
    chk("add_valid", bif.ms_to_ws_valid, 1'b1);
    step();
    exp_q.push_back(ws(1'b1, 5'd0, 32'h42, 32'h804));
    send(es(1'b0, LD_0, 1'b0, 1'b1, 5'd0, 32'h42, 32'h804));
    @(negedge clk);
    chk("add_r0_fwd_we", bif.ms_fwd_bus[FWD_WE], 1'b0);
    step();

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
